mem_bus_ctrl: RTL

//  Memory bus controller between the XM23 CPU datapath (MAR/MDR, control register) and the dual byte-lane RAM.

---
 rtl/mem_bus_ctrl.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/mem_bus_ctrl.sv
// Memory bus controller: sequences the XM23 dual byte-lane RAM for one word/byte access at a time.
// Optional misaligned-word trap is enabled with the ALIGN_CHK_EN macro.
module mem_bus_ctrl #(
  parameter int WAIT_STATES = 0,
  parameter int ADDR_W      = 16
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              req_i,
  input  logic              rw_i,
  input  logic              byte_mode_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [15:0]       wdata_i,
  output logic [15:0]       rdata_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [ADDR_W-1:0] mem_lb_addr_o,
  output logic [ADDR_W-1:0] mem_ub_addr_o,
  output logic [7:0]        mem_lb_wdata_o,
  output logic [7:0]        mem_ub_wdata_o,
  output logic              mem_lb_we_o,
  output logic              mem_ub_we_o,
  input  logic [7:0]        mem_lb_rdata_i,
  input  logic [7:0]        mem_ub_rdata_i
);

  localparam int         WCYC  = (WAIT_STATES < 1) ? 1 : WAIT_STATES;
  localparam logic [3:0] WLOAD = 4'(WCYC - 1);

  typedef enum logic [1:0] {IDLE, ADDR, WAIT, DONE} state_e;
  typedef struct packed {
    logic rw;
    logic bm;
  } req_t;

  state_e                       state_q, state_d;
  req_t                         req_q, req_d;
  logic [1:0][ADDR_W-1:0]       la_q, la_d;   // [0]=low lane, [1]=high lane
  logic [1:0][7:0]              lw_q, lw_d;
  logic [1:0]                   we_q, we_d;
  logic [3:0]                   cnt_q, cnt_d;
  logic                         busy_q, busy_d;
  logic                         done_q, done_d;
  logic [15:0]                  rdata_q, rdata_d;
`ifdef ALIGN_CHK_EN
  logic                         err_q, err_d;
`endif

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    la_d    = la_q;
    lw_d    = lw_q;
    we_d    = 2'b00;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    rdata_d = rdata_q;
`ifdef ALIGN_CHK_EN
    err_d   = 1'b0;
`endif
    unique case (state_q)
      IDLE: if (req_i) begin
        req_d  = '{rw: rw_i, bm: byte_mode_i};
        busy_d = 1'b1;
`ifdef ALIGN_CHK_EN
        if (!byte_mode_i && addr_i[0]) begin
          state_d = DONE;
          err_d   = 1'b1;
        end else
`endif
        begin
          state_d = ADDR;
          // Word accesses force an even low-lane address; bytes use the raw address.
          if (byte_mode_i) begin
            la_d[0] = addr_i;
            la_d[1] = addr_i + ADDR_W'(1);
          end else begin
            la_d[0] = {addr_i[ADDR_W-1:1], 1'b0};
            la_d[1] = {addr_i[ADDR_W-1:1], 1'b1};
          end
          lw_d = wdata_i;
          we_d = rw_i ? {~byte_mode_i, 1'b1} : 2'b00;
        end
      end
      ADDR: begin
        state_d = WAIT;
        cnt_d   = WLOAD;
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = DONE;
          if (!req_q.rw)
            rdata_d = req_q.bm ? {8'h00, mem_lb_rdata_i} : {mem_ub_rdata_i, mem_lb_rdata_i};
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      req_q   <= '0;
      la_q    <= '0;
      lw_q    <= '0;
      we_q    <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rdata_q <= '0;
`ifdef ALIGN_CHK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      la_q    <= la_d;
      lw_q    <= lw_d;
      we_q    <= we_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rdata_q <= rdata_d;
`ifdef ALIGN_CHK_EN
      err_q   <= err_d;
`endif
    end
  end

  assign rdata_o        = rdata_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign mem_lb_addr_o  = la_q[0];
  assign mem_ub_addr_o  = la_q[1];
  assign mem_lb_wdata_o = lw_q[0];
  assign mem_ub_wdata_o = lw_q[1];
  assign mem_lb_we_o    = we_q[0];
  assign mem_ub_we_o    = we_q[1];
`ifdef ALIGN_CHK_EN
  assign err_o          = err_q;
`else
  assign err_o          = 1'b0;
`endif

endmodule
